// File: rtl/data_sram_responder_pkg.sv
// Shared constants, request payload and helpers for the data SRAM responder.
// MMIO offsets and UART_STAT bit positions mirror the software-side register map.
package data_sram_responder_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam logic [15:0] MMIO_BASE_DEFAULT = 16'hBFAF;

  localparam logic [15:0] OFF_LED       = 16'hF000;
  localparam logic [15:0] OFF_SWITCH    = 16'hF004;
  localparam logic [15:0] OFF_TIMER     = 16'hF008;
  localparam logic [15:0] OFF_SIMU_FLAG = 16'hF00C;
  localparam logic [15:0] OFF_UART_DATA = 16'hFFF0;
  localparam logic [15:0] OFF_UART_STAT = 16'hFFF4;

  localparam int unsigned UART_STAT_OVF_BIT = 8;
  localparam int unsigned UART_STAT_CNT_LSB = 0;

  typedef struct packed {
    logic              en;
    logic [BE_W-1:0]   we;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } sram_req_t;

  typedef enum logic [2:0] {
    MMIO_NONE,
    MMIO_LED,
    MMIO_SWITCH,
    MMIO_TIMER,
    MMIO_SIMU,
    MMIO_UART_DATA,
    MMIO_UART_STAT
  } mmio_sel_e;

  // Replace the byte lanes of old_w selected by we with those of new_w.
  function automatic logic [WORD_W-1:0] byte_merge(input logic [WORD_W-1:0] old_w,
                                                   input logic [WORD_W-1:0] new_w,
                                                   input logic [BE_W-1:0]   we);
    logic [WORD_W-1:0] r;
    r = old_w;
    for (int i = 0; i < int'(BE_W); i++) begin
      if (we[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  function automatic mmio_sel_e decode_offset(input logic [15:0] off);
    case (off)
      OFF_LED:       return MMIO_LED;
      OFF_SWITCH:    return MMIO_SWITCH;
      OFF_TIMER:     return MMIO_TIMER;
      OFF_SIMU_FLAG: return MMIO_SIMU;
      OFF_UART_DATA: return MMIO_UART_DATA;
      OFF_UART_STAT: return MMIO_UART_STAT;
      default:       return MMIO_NONE;
    endcase
  endfunction

endpackage

// File: rtl/data_sram_responder_uart_tx_fifo.sv
// UART transmit FIFO: power-of-two ring buffer with a combinational head.
// A push while full is accepted only when a pop frees the head slot in the same cycle.
module data_sram_responder_uart_tx_fifo #(
  parameter int unsigned UART_DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(UART_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [7:0]       push_data,
  input  logic             pop_ready,
  output logic             valid,
  output logic [7:0]       head,
  output logic [CNT_W-1:0] count,
  output logic             dropped
);

  localparam int unsigned PTR_W = (UART_DEPTH > 1) ? $clog2(UART_DEPTH) : 1;

  logic [7:0]       mem [UART_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             full;
  logic             pop;
  logic             accept;

  assign full    = (cnt == CNT_W'(UART_DEPTH));
  assign valid   = (cnt != '0);
  assign pop     = valid && pop_ready;
  assign accept  = push && (!full || pop);
  assign dropped = push && full && !pop;
  assign count   = cnt;
  // Head reads as zero when empty so the output is clean out of reset.
  assign head    = valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/data_sram_responder.sv
// Data SRAM responder: byte-writable word RAM plus an MMIO page (LED, switches,
// timer, simulation flag, UART TX FIFO), read data returned one cycle after the request.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int unsigned RAM_AW     = 14,
  parameter logic [15:0] MMIO_BASE  = MMIO_BASE_DEFAULT,
  parameter int unsigned UART_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [15:0] switch_in,
  output logic [15:0] led_out,
  output logic        uart_tx_valid,
  output logic [7:0]  uart_tx_data,
  input  logic        uart_tx_ready
);

  localparam int unsigned RAM_DEPTH = 1 << RAM_AW;
  localparam int unsigned CNT_W     = $clog2(UART_DEPTH + 1);

  sram_req_t          req;
  logic               is_mmio;
  mmio_sel_e          sel;
  logic [RAM_AW-1:0]  ram_idx;
  logic               has_we;
  logic [WORD_W-1:0]  ram [RAM_DEPTH];
  logic [WORD_W-1:0]  ram_word;

  logic [15:0]        led_q;
  logic [WORD_W-1:0]  timer_q;
  logic [WORD_W-1:0]  simu_q;
  logic               ovf_q;
  logic [WORD_W-1:0]  rdata_q;

  logic [15:0]        led_next;
  logic [WORD_W-1:0]  stat_word;
  logic [WORD_W-1:0]  rdata_next;
  logic               uart_push;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_dropped;
  logic               unused_addr_bits;

  assign req = '{en: data_sram_en, we: data_sram_we, addr: data_sram_addr, wdata: data_sram_wdata};
  assign unused_addr_bits = ^req.addr[1:0];

  assign is_mmio   = (req.addr[31:16] == MMIO_BASE);
  assign sel       = is_mmio ? decode_offset(req.addr[15:0]) : MMIO_NONE;
  assign ram_idx   = req.addr[RAM_AW+1:2];
  assign has_we    = (req.we != '0);
  assign ram_word  = ram[ram_idx];
  assign uart_push = req.en && (sel == MMIO_UART_DATA) && req.we[0];

  // RAM is deliberately outside reset; read port is asynchronous so rdata sees the pre-write word.
  always_ff @(posedge clk) begin
    if (req.en && !is_mmio && has_we) ram[ram_idx] <= byte_merge(ram_word, req.wdata, req.we);
  end

  always_comb begin
    led_next = led_q;
    if (req.we[0]) led_next[7:0]  = req.wdata[7:0];
    if (req.we[1]) led_next[15:8] = req.wdata[15:8];
  end

  always_comb begin
    stat_word = '0;
    stat_word[UART_STAT_OVF_BIT] = ovf_q;
    stat_word[UART_STAT_CNT_LSB +: CNT_W] = fifo_count;
  end

  always_comb begin
    rdata_next = '0;
    if (!is_mmio) begin
      rdata_next = ram_word;
    end else begin
      case (sel)
        MMIO_LED:       rdata_next = {16'h0000, led_q};
        MMIO_SWITCH:    rdata_next = {16'h0000, switch_in};
        MMIO_TIMER:     rdata_next = timer_q;
        MMIO_SIMU:      rdata_next = simu_q;
        MMIO_UART_STAT: rdata_next = stat_word;
        default:        rdata_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
      led_q   <= '0;
      timer_q <= '0;
      simu_q  <= '1;
      ovf_q   <= 1'b0;
    end else begin
      if (req.en) rdata_q <= rdata_next;
      if (req.en && sel == MMIO_LED) led_q <= led_next;
      if (req.en && sel == MMIO_SIMU) simu_q <= byte_merge(simu_q, req.wdata, req.we);
      // A software write to the timer takes priority over the free-running increment.
      if (req.en && sel == MMIO_TIMER && has_we) timer_q <= byte_merge(timer_q, req.wdata, req.we);
      else timer_q <= timer_q + 1'b1;
      if (req.en && sel == MMIO_UART_STAT && has_we) ovf_q <= 1'b0;
      else if (fifo_dropped) ovf_q <= 1'b1;
    end
  end

  data_sram_responder_uart_tx_fifo #(
    .UART_DEPTH(UART_DEPTH)
  ) u_uart_tx_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (uart_push),
    .push_data(req.wdata[7:0]),
    .pop_ready(uart_tx_ready),
    .valid    (uart_tx_valid),
    .head     (uart_tx_data),
    .count    (fifo_count),
    .dropped  (fifo_dropped)
  );

  assign data_sram_rdata = rdata_q;
  assign led_out         = led_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed self-checking bench for data_sram_responder.
module tb_data_sram_responder;

  logic        clk;
  logic        reset;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [15:0] switch_in;
  logic [15:0] led_out;
  logic        uart_tx_valid;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_ready;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [31:0] A_LED   = 32'hBFAF_F000;
  localparam logic [31:0] A_SW    = 32'hBFAF_F004;
  localparam logic [31:0] A_TIMER = 32'hBFAF_F008;
  localparam logic [31:0] A_SIMU  = 32'hBFAF_F00C;
  localparam logic [31:0] A_UDATA = 32'hBFAF_FFF0;
  localparam logic [31:0] A_USTAT = 32'hBFAF_FFF4;

  data_sram_responder dut (
    .clk            (clk),
    .reset          (reset),
    .data_sram_en   (data_sram_en),
    .data_sram_we   (data_sram_we),
    .data_sram_addr (data_sram_addr),
    .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata),
    .switch_in      (switch_in),
    .led_out        (led_out),
    .uart_tx_valid  (uart_tx_valid),
    .uart_tx_data   (uart_tx_data),
    .uart_tx_ready  (uart_tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, observed, expected);
    end
  endtask

  // One bus cycle: drive request, then step to 1ns after the closing edge.
  task automatic bus(input logic en, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
    data_sram_en    = en;
    data_sram_we    = we;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) bus(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    data_sram_en = 1'b0;
    data_sram_we = 4'h0;
    data_sram_addr = 32'h0;
    data_sram_wdata = 32'h0;
    switch_in = 16'h0000;
    uart_tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rdata", data_sram_rdata, 32'h0);
    check("reset_led", 32'(led_out), 32'h0);
    check("reset_tx_valid", 32'(uart_tx_valid), 32'h0);
    check("reset_tx_data", 32'(uart_tx_data), 32'h0);
    reset = 1'b0;

    // RAM byte writes and read-before-write
    bus(1'b1, 4'hF, 32'h0000_0010, 32'h1234_5678);
    bus(1'b1, 4'b0010, 32'h0000_0010, 32'hAABB_CCDD);
    check("ram_pre_write", data_sram_rdata, 32'h1234_5678);
    bus(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    check("ram_byte_merge", data_sram_rdata, 32'h1234_CC78);
    idle(2);
    check("rdata_hold", data_sram_rdata, 32'h1234_CC78);
    bus(1'b1, 4'hF, 32'h0000_0014, 32'hCAFE_F00D);
    bus(1'b1, 4'h0, 32'h0002_0014, 32'h0);
    check("ram_alias", data_sram_rdata, 32'hCAFE_F00D);

    // Switches and LED
    switch_in = 16'hA5A5;
    bus(1'b1, 4'h0, A_SW, 32'h0);
    check("switch_read", data_sram_rdata, 32'h0000_A5A5);
    bus(1'b1, 4'hF, A_LED, 32'hFFFF_00F0);
    check("led_full_write", 32'(led_out), 32'h0000_00F0);
    bus(1'b1, 4'b0010, A_LED, 32'h0000_3300);
    check("led_byte_write", 32'(led_out), 32'h0000_33F0);
    bus(1'b1, 4'h0, A_LED, 32'h0);
    check("led_read", data_sram_rdata, 32'h0000_33F0);

    // Simulation flag and unmapped offsets
    bus(1'b1, 4'h0, A_SIMU, 32'h0);
    check("simu_reset_value", data_sram_rdata, 32'hFFFF_FFFF);
    bus(1'b1, 4'b0001, A_SIMU, 32'h0);
    bus(1'b1, 4'h0, A_SIMU, 32'h0);
    check("simu_byte_write", data_sram_rdata, 32'hFFFF_FF00);
    bus(1'b1, 4'h0, 32'hBFAF_F010, 32'h0);
    check("unmapped_read", data_sram_rdata, 32'h0);

    // Timer: 0x10 loaded at the write edge, then 5 idle edges before the read cycle
    bus(1'b1, 4'hF, A_TIMER, 32'h0000_0010);
    idle(5);
    bus(1'b1, 4'h0, A_TIMER, 32'h0);
    check("timer_count", data_sram_rdata, 32'h0000_0015);
    bus(1'b1, 4'h0, A_TIMER, 32'h0);
    check("timer_next", data_sram_rdata, 32'h0000_0016);

    // UART overflow, clear, drain in order
    for (int i = 1; i <= 5; i++) bus(1'b1, 4'b0001, A_UDATA, 32'(8'h11 * i));
    check("uart_head_valid", 32'(uart_tx_valid), 32'h1);
    check("uart_head_data", 32'(uart_tx_data), 32'h11);
    bus(1'b1, 4'h0, A_USTAT, 32'h0);
    check("uart_stat_ovf", data_sram_rdata, 32'h0000_0104);
    bus(1'b1, 4'hF, A_USTAT, 32'h0);
    bus(1'b1, 4'h0, A_USTAT, 32'h0);
    check("uart_stat_cleared", data_sram_rdata, 32'h0000_0004);
    bus(1'b1, 4'h0, A_UDATA, 32'h0);
    check("uart_data_read", data_sram_rdata, 32'h0);
    data_sram_en = 1'b0;
    uart_tx_ready = 1'b1;
    #1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_valid", 32'(uart_tx_valid), 32'h1);
      check("drain_data", 32'(uart_tx_data), 32'(8'h11 * i));
      @(posedge clk);
      #1;
    end
    check("drain_empty", 32'(uart_tx_valid), 32'h0);
    check("drain_empty_data", 32'(uart_tx_data), 32'h0);

    // Full FIFO with simultaneous push and pop
    uart_tx_ready = 1'b0;
    for (int i = 1; i <= 4; i++) bus(1'b1, 4'b0001, A_UDATA, 32'h0000_00A0 + 32'(i));
    uart_tx_ready = 1'b1;
    bus(1'b1, 4'b0001, A_UDATA, 32'h0000_00A5);
    uart_tx_ready = 1'b0;
    bus(1'b1, 4'h0, A_USTAT, 32'h0);
    check("full_pushpop_stat", data_sram_rdata, 32'h0000_0004);
    data_sram_en = 1'b0;
    uart_tx_ready = 1'b1;
    #1;
    for (int i = 2; i <= 5; i++) begin
      check("pushpop_drain", 32'(uart_tx_data), 32'h0000_00A0 + 32'(i));
      @(posedge clk);
      #1;
    end
    check("pushpop_empty", 32'(uart_tx_valid), 32'h0);
    uart_tx_ready = 1'b0;

    // Asynchronous reset in the middle of activity
    bus(1'b1, 4'b0001, A_UDATA, 32'h0000_0077);
    bus(1'b1, 4'hF, A_LED, 32'h0000_1234);
    bus(1'b1, 4'h0, A_TIMER, 32'h0);
    data_sram_en = 1'b0;
    reset = 1'b1;
    #1;
    check("midreset_rdata", data_sram_rdata, 32'h0);
    check("midreset_led", 32'(led_out), 32'h0);
    check("midreset_tx_valid", 32'(uart_tx_valid), 32'h0);
    check("midreset_tx_data", 32'(uart_tx_data), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus(1'b1, 4'h0, A_TIMER, 32'h0);
    check("timer_after_reset", data_sram_rdata, 32'h0);
    bus(1'b1, 4'h0, A_SIMU, 32'h0);
    check("simu_after_reset", data_sram_rdata, 32'hFFFF_FFFF);
    bus(1'b1, 4'h0, A_USTAT, 32'h0);
    check("stat_after_reset", data_sram_rdata, 32'h0);
    bus(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    check("ram_kept_over_reset", data_sram_rdata, 32'h1234_CC78);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
